// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register of the 5-stage RISC-V core.
// Owns the PC, flushes the wrong-path fetch on a taken branch, and keeps taken/stall counters.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             branch_taken_i,
  input  logic [31:0]      branch_pc_i,
  input  logic [31:0]      instr_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      if_id_pc_o,
  output logic [31:0]      if_id_instr_o,
  output logic             if_id_valid_o,
  output logic [CNT_W-1:0] taken_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic             misalign_o
);

  typedef enum logic [1:0] {
    ACT_FREEZE   = 2'd0,
    ACT_STALL    = 2'd1,
    ACT_REDIRECT = 2'd2,
    ACT_FETCH    = 2'd3
  } fetch_act_e;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  // Saturating increment: an all-ones counter stays at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  logic [31:0]      pc_r, pc_nxt_s;
  logic [31:0]      if_id_pc_r, if_id_pc_nxt_s;
  logic [31:0]      if_id_instr_r, if_id_instr_nxt_s;
  logic             if_id_valid_r, if_id_valid_nxt_s;
  logic [CNT_W-1:0] taken_cnt_r, taken_cnt_nxt_s;
  logic [CNT_W-1:0] stall_cnt_r, stall_cnt_nxt_s;
  logic             misalign_r, misalign_nxt_s;
  logic             taken_q_s;
  fetch_act_e       act_s;

  // A bubble in ID can never redirect fetch.
  assign taken_q_s = branch_taken_i & if_id_valid_r;

  // Select this cycle's action in priority order: freeze, stall, redirect, sequential fetch.
  always_comb begin
    act_s = ACT_FETCH;
    if (!start_i) begin
      act_s = ACT_FREEZE;
    end else if (stall_i) begin
      act_s = ACT_STALL;
    end else if (taken_q_s) begin
      act_s = ACT_REDIRECT;
    end else begin
      act_s = ACT_FETCH;
    end
  end

  // Next-state values for the PC, IF/ID register, counters and sticky flag.
  always_comb begin
    pc_nxt_s          = pc_r;
    if_id_pc_nxt_s    = if_id_pc_r;
    if_id_instr_nxt_s = if_id_instr_r;
    if_id_valid_nxt_s = if_id_valid_r;
    taken_cnt_nxt_s   = taken_cnt_r;
    stall_cnt_nxt_s   = stall_cnt_r;
    misalign_nxt_s    = misalign_r;
    case (act_s)
      ACT_FREEZE: begin
        if_id_pc_nxt_s    = pc_r;
        if_id_instr_nxt_s = NOP_INSTR;
        if_id_valid_nxt_s = 1'b0;
      end
      ACT_STALL: begin
        // The stalled branch re-resolves next cycle, so it is not counted here.
        stall_cnt_nxt_s = sat_inc(stall_cnt_r);
      end
      ACT_REDIRECT: begin
        pc_nxt_s          = branch_pc_i;
        if_id_pc_nxt_s    = pc_r;
        if_id_instr_nxt_s = NOP_INSTR;
        if_id_valid_nxt_s = 1'b0;
        taken_cnt_nxt_s   = sat_inc(taken_cnt_r);
        if (branch_pc_i[1:0] != 2'b00) begin
          misalign_nxt_s = 1'b1;
        end else begin
          misalign_nxt_s = misalign_r;
        end
      end
      ACT_FETCH: begin
        pc_nxt_s          = pc_r + 32'd4;
        if_id_pc_nxt_s    = pc_r;
        if_id_instr_nxt_s = instr_i;
        if_id_valid_nxt_s = 1'b1;
      end
      default: begin
        pc_nxt_s          = pc_r;
        if_id_pc_nxt_s    = if_id_pc_r;
        if_id_instr_nxt_s = if_id_instr_r;
        if_id_valid_nxt_s = if_id_valid_r;
      end
    endcase
  end

  // State registers with immediate asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_r          <= RESET_PC;
      if_id_pc_r    <= 32'h0000_0000;
      if_id_instr_r <= NOP_INSTR;
      if_id_valid_r <= 1'b0;
      taken_cnt_r   <= CNT_ZERO;
      stall_cnt_r   <= CNT_ZERO;
      misalign_r    <= 1'b0;
    end else begin
      pc_r          <= pc_nxt_s;
      if_id_pc_r    <= if_id_pc_nxt_s;
      if_id_instr_r <= if_id_instr_nxt_s;
      if_id_valid_r <= if_id_valid_nxt_s;
      taken_cnt_r   <= taken_cnt_nxt_s;
      stall_cnt_r   <= stall_cnt_nxt_s;
      misalign_r    <= misalign_nxt_s;
    end
  end

  assign pc_o          = pc_r;
  assign if_id_pc_o    = if_id_pc_r;
  assign if_id_instr_o = if_id_instr_r;
  assign if_id_valid_o = if_id_valid_r;
  assign taken_cnt_o   = taken_cnt_r;
  assign stall_cnt_o   = stall_cnt_r;
  assign misalign_o    = misalign_r;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a default instance for fetch/branch/stall behaviour and a
// narrow-counter instance starting at the top of the address space for saturation and PC wrap.
module tb_if_fetch_stage;

  logic        clk_s;
  logic        rst_s;
  logic        start_s, stall_s, br_s;
  logic [31:0] bpc_s, instr_s;
  logic [31:0] pc_s, ifpc_s, ifinstr_s;
  logic        ifvalid_s, mis_s;
  logic [31:0] tcnt_s, scnt_s;

  logic        start1_s, stall1_s, br1_s;
  logic [31:0] bpc1_s, instr1_s;
  logic [31:0] pc1_s, ifpc1_s, ifinstr1_s;
  logic        ifvalid1_s, mis1_s;
  logic [3:0]  tcnt1_s, scnt1_s;

  int n_checks;
  int n_fails;

  if_fetch_stage dut (
    .clk_i(clk_s), .rst_i(rst_s), .start_i(start_s), .stall_i(stall_s),
    .branch_taken_i(br_s), .branch_pc_i(bpc_s), .instr_i(instr_s),
    .pc_o(pc_s), .if_id_pc_o(ifpc_s), .if_id_instr_o(ifinstr_s), .if_id_valid_o(ifvalid_s),
    .taken_cnt_o(tcnt_s), .stall_cnt_o(scnt_s), .misalign_o(mis_s)
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0013), .CNT_W(4)) dut_small (
    .clk_i(clk_s), .rst_i(rst_s), .start_i(start1_s), .stall_i(stall1_s),
    .branch_taken_i(br1_s), .branch_pc_i(bpc1_s), .instr_i(instr1_s),
    .pc_o(pc1_s), .if_id_pc_o(ifpc1_s), .if_id_instr_o(ifinstr1_s), .if_id_valid_o(ifvalid1_s),
    .taken_cnt_o(tcnt1_s), .stall_cnt_o(scnt1_s), .misalign_o(mis1_s)
  );

  // Instruction memory model: word at address a reads as a | 0xA000_0000.
  assign instr_s  = pc_s  | 32'hA000_0000;
  assign instr1_s = pc1_s | 32'hA000_0000;

  initial begin
    clk_s = 1'b0;
    forever #5 clk_s = ~clk_s;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_s);
      #1;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_s = 1'b1;
    start_s = 1'b0; stall_s = 1'b0; br_s = 1'b0; bpc_s = 32'h0;
    start1_s = 1'b0; stall1_s = 1'b0; br1_s = 1'b0; bpc1_s = 32'h0;
    #2;
    check_eq("rst_pc", pc_s, 32'h0);
    check_eq("rst_valid", {31'b0, ifvalid_s}, 32'h0);
    check_eq("rst_instr", ifinstr_s, 32'h13);
    check_eq("rst_ifpc", ifpc_s, 32'h0);
    check_eq("rst_cnts", tcnt_s | scnt_s, 32'h0);
    check_eq("rst_pc_small", pc1_s, 32'hFFFF_FFFC);
    #1;
    rst_s = 1'b0;
    start_s = 1'b1;

    // Sequential fetch
    step(3);
    check_eq("seq_pc", pc_s, 32'd12);
    check_eq("seq_ifpc", ifpc_s, 32'd8);
    check_eq("seq_instr", ifinstr_s, 32'hA000_0008);
    check_eq("seq_valid", {31'b0, ifvalid_s}, 32'h1);

    // Taken branch from pc 16
    step(1);
    check_eq("pre_br_pc", pc_s, 32'd16);
    br_s = 1'b1; bpc_s = 32'h40;
    step(1);
    br_s = 1'b0;
    check_eq("br_pc", pc_s, 32'h40);
    check_eq("br_valid", {31'b0, ifvalid_s}, 32'h0);
    check_eq("br_instr", ifinstr_s, 32'h13);
    check_eq("br_tcnt", tcnt_s, 32'd1);
    step(1);
    check_eq("br_tgt_ifpc", ifpc_s, 32'h40);
    check_eq("br_tgt_instr", ifinstr_s, 32'hA000_0040);
    check_eq("br_tgt_pc", pc_s, 32'h44);

    // Stall overrides branch
    stall_s = 1'b1; br_s = 1'b1; bpc_s = 32'h80;
    step(2);
    check_eq("stall_pc", pc_s, 32'h44);
    check_eq("stall_ifpc", ifpc_s, 32'h40);
    check_eq("stall_valid", {31'b0, ifvalid_s}, 32'h1);
    check_eq("stall_scnt", scnt_s, 32'd2);
    check_eq("stall_tcnt", tcnt_s, 32'd1);
    stall_s = 1'b0;
    step(1);
    br_s = 1'b0;
    check_eq("unstall_pc", pc_s, 32'h80);
    check_eq("unstall_valid", {31'b0, ifvalid_s}, 32'h0);
    check_eq("unstall_tcnt", tcnt_s, 32'd2);

    // Branch while ID holds a bubble is ignored
    br_s = 1'b1; bpc_s = 32'h100;
    step(1);
    check_eq("bubble_br_pc", pc_s, 32'h84);
    check_eq("bubble_br_tcnt", tcnt_s, 32'd2);
    check_eq("bubble_br_valid", {31'b0, ifvalid_s}, 32'h1);

    // Misaligned target is loaded unmodified and sets the sticky flag
    bpc_s = 32'h42;
    step(1);
    br_s = 1'b0;
    check_eq("mis_pc", pc_s, 32'h42);
    check_eq("mis_flag", {31'b0, mis_s}, 32'h1);
    check_eq("mis_tcnt", tcnt_s, 32'd3);
    step(2);
    check_eq("mis_seq_pc", pc_s, 32'h4A);
    check_eq("mis_seq_ifpc", ifpc_s, 32'h46);
    br_s = 1'b1; bpc_s = 32'h200;
    step(1);
    br_s = 1'b0;
    check_eq("mis_br2_pc", pc_s, 32'h200);
    check_eq("mis_sticky", {31'b0, mis_s}, 32'h1);

    // start_i low freezes fetch even with stall/branch asserted
    step(1);
    start_s = 1'b0; stall_s = 1'b1; br_s = 1'b1; bpc_s = 32'h300;
    step(2);
    check_eq("frz_pc", pc_s, 32'h204);
    check_eq("frz_valid", {31'b0, ifvalid_s}, 32'h0);
    check_eq("frz_ifpc", ifpc_s, 32'h204);
    check_eq("frz_instr", ifinstr_s, 32'h13);
    check_eq("frz_scnt", scnt_s, 32'd2);
    check_eq("frz_tcnt", tcnt_s, 32'd4);
    stall_s = 1'b0; br_s = 1'b0;

    // Reset asserted mid-cycle takes effect without a clock edge
    #3;
    rst_s = 1'b1;
    #1;
    check_eq("mid_rst_pc", pc_s, 32'h0);
    check_eq("mid_rst_instr", ifinstr_s, 32'h13);
    check_eq("mid_rst_mis", {31'b0, mis_s}, 32'h0);
    check_eq("mid_rst_tcnt", tcnt_s, 32'h0);
    check_eq("mid_rst_scnt", scnt_s, 32'h0);
    @(negedge clk_s);
    rst_s = 1'b0;

    // Narrow instance: PC wrap, counter saturation, freeze
    start1_s = 1'b1;
    step(1);
    check_eq("wrap_pc", pc1_s, 32'h0);
    check_eq("wrap_ifpc", ifpc1_s, 32'hFFFF_FFFC);
    check_eq("wrap_instr", ifinstr1_s, 32'hFFFF_FFFC);
    stall1_s = 1'b1;
    step(14);
    check_eq("sat_14", {28'b0, scnt1_s}, 32'd14);
    step(6);
    check_eq("sat_20", {28'b0, scnt1_s}, 32'd15);
    check_eq("sat_pc", pc1_s, 32'h0);
    stall1_s = 1'b0; start1_s = 1'b0;
    step(2);
    check_eq("small_frz_pc", pc1_s, 32'h0);
    check_eq("small_frz_valid", {31'b0, ifvalid1_s}, 32'h0);
    check_eq("small_frz_scnt", {28'b0, scnt1_s}, 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
